change_dispenser: RTL

Coin-payout back end of the vending path. Accepts the change code produced by the vending controller at the end of a transaction and pays it out physically by pulsing 10 rs and 5 rs hopper solenoids one coin at a time. Each coin is confirmed by the hopper drop sensor before the next is fired. Reports completion, the amount actually paid, and faults (sensor timeout, empty hopper, illegal code).

---
 rtl/change_dispenser.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: coin-payout back end. Pays a 5 rs-unit change code by
// firing 10 rs / 5 rs hopper solenoids one coin at a time, each confirmed by
// the drop sensor. Reports done, paid amount and sticky faults.
// Optional feature macro: CHG_SUBST_EN (substitute 5 rs coins when the
// 10 rs hopper is empty).
module change_dispenser #(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned ACK_TIMEOUT  = 255,
  parameter int unsigned TO_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [2:0] change,
  input  logic       hop10_empty,
  input  logic       hop5_empty,
  input  logic       coin_seen,
  input  logic       fault_clr,
  output logic       hop10_fire,
  output logic       hop5_fire,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [2:0] paid
);

  localparam int unsigned PC_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_FIRE,
    S_WAIT,
    S_DONE,
    S_FAULT
  } state_t;

  state_t            state_q, state_n;
  logic [2:0]        rem_q, rem_n;
  logic              coin_q, coin_n;     // 1 = 10 rs, 0 = 5 rs
  logic [PC_W-1:0]   pcnt_q, pcnt_n;
  logic [TO_W-1:0]   tcnt_q, tcnt_n;
  logic              seen_q, seen_n;     // coin_seen recorded during FIRE
  logic [2:0]        paid_q, paid_n;
  logic [2:0]        step;

  // State and datapath registers; reset drops every output decode at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      coin_q  <= 1'b0;
      pcnt_q  <= '0;
      tcnt_q  <= '0;
      seen_q  <= 1'b0;
      paid_q  <= '0;
    end else begin
      state_q <= state_n;
      rem_q   <= rem_n;
      coin_q  <= coin_n;
      pcnt_q  <= pcnt_n;
      tcnt_q  <= tcnt_n;
      seen_q  <= seen_n;
      paid_q  <= paid_n;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_n = state_q;
    rem_n   = rem_q;
    coin_n  = coin_q;
    pcnt_n  = pcnt_q;
    tcnt_n  = tcnt_q;
    seen_n  = seen_q;
    paid_n  = paid_q;
    step    = coin_q ? 3'd2 : 3'd1;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          paid_n = '0;
          if (change == 3'd0) begin
            state_n = S_DONE;
          end else if (change <= 3'd4) begin
            rem_n   = change;
            state_n = S_SELECT;
          end else begin
            state_n = S_FAULT;
          end
        end
      end

      S_SELECT: begin
        seen_n = 1'b0;
        pcnt_n = '0;
        tcnt_n = '0;
        if (rem_q == 3'd0) begin
          state_n = S_DONE;
        end else if (rem_q >= 3'd2) begin
          if (!hop10_empty) begin
            coin_n  = 1'b1;
            state_n = S_FIRE;
          end
`ifdef CHG_SUBST_EN
          else if (!hop5_empty) begin
            coin_n  = 1'b0;
            state_n = S_FIRE;
          end
`endif
          else begin
            state_n = S_FAULT;
          end
        end else if (!hop5_empty) begin
          coin_n  = 1'b0;
          state_n = S_FIRE;
        end else begin
          state_n = S_FAULT;
        end
      end

      S_FIRE: begin
        if (coin_seen) begin
          seen_n = 1'b1;
        end
        if (pcnt_q == PC_W'(PULSE_CYCLES - 1)) begin
          state_n = S_WAIT;
        end else begin
          pcnt_n = pcnt_q + PC_W'(1);
        end
      end

      S_WAIT: begin
        if (coin_seen || seen_q) begin
          rem_n   = rem_q - step;
          paid_n  = paid_q + step;
          seen_n  = 1'b0;
          state_n = S_SELECT;
        end else if (tcnt_q == TO_W'(ACK_TIMEOUT)) begin
          state_n = S_FAULT;
        end else begin
          tcnt_n = tcnt_q + TO_W'(1);
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
      end

      S_FAULT: begin
        if (fault_clr) begin
          state_n = S_IDLE;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only
  assign hop10_fire = (state_q == S_FIRE) && coin_q;
  assign hop5_fire  = (state_q == S_FIRE) && !coin_q;
  assign busy       = (state_q == S_SELECT) || (state_q == S_FIRE) ||
                      (state_q == S_WAIT)   || (state_q == S_DONE);
  assign done       = (state_q == S_DONE);
  assign fault      = (state_q == S_FAULT);
  assign paid       = paid_q;

endmodule
